// File: rtl/sprite_palette_pkg.sv
// Shared types and reset contents for the sprite palette unit.
package sprite_palette_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FADING,
        DARK
    } fade_state_t;

    localparam int DEFAULT_ENTRIES = 16;

    // Packed {R,G,B}, one nibble per component.
    localparam logic [11:0] DEFAULT_PALETTE [DEFAULT_ENTRIES] = '{
        12'hF92, 12'hFFF, 12'h621, 12'hFF0, 12'hF31, 12'hE97, 12'h555, 12'hFB1,
        12'h221, 12'hE64, 12'hF71, 12'hAAA, 12'hFED, 12'hFD0, 12'hFBB, 12'hA32
    };

endpackage

// File: rtl/palette_scale.sv
// Scales one colour component by a brightness level; full level is identity.
module palette_scale
    import sprite_palette_pkg::*;
#(
    parameter int COMP_W = 4
) (
    input  logic [COMP_W-1:0] comp_i,
    input  logic [COMP_W-1:0] level_i,
    output logic [COMP_W-1:0] scaled_o
);

    function automatic logic [COMP_W-1:0] scale(input logic [COMP_W-1:0] c,
                                                input logic [COMP_W-1:0] l);
        logic [2*COMP_W-1:0] prod;
        prod = (2*COMP_W)'(c) * ((2*COMP_W)'(l) + (2*COMP_W)'(1));
        return prod[2*COMP_W-1:COMP_W];
    endfunction

    assign scaled_o = scale(comp_i, level_i);

endmodule

// File: rtl/sprite_palette_unit.sv
// Banked colour palette with 2-cycle lookup pipeline and a frame-stepped fade-out.
module sprite_palette_unit
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int COMP_W     = 4,
    parameter int NUM_BANKS  = 2,
    parameter int TRANSP_IDX = 0
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         in_valid,
    input  logic [$clog2(NUM_BANKS)-1:0] in_bank,
    input  logic [IDX_W-1:0]             in_index,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
    input  logic [IDX_W-1:0]             wr_index,
    input  logic [3*COMP_W-1:0]          wr_data,
    input  logic                         fade_start,
    input  logic                         fade_restore,
    input  logic                         fade_tick,
    output logic                         out_valid,
    output logic [COMP_W-1:0]            red,
    output logic [COMP_W-1:0]            green,
    output logic [COMP_W-1:0]            blue,
    output logic                         out_transparent,
    output logic                         fade_busy,
    output logic [COMP_W-1:0]            brightness
);

    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int DEPTH   = 2**IDX_W;
    localparam int ENTRY_W = 3*COMP_W;
    localparam logic [COMP_W-1:0] BRIGHT_MAX = '1;

    function automatic logic [ENTRY_W-1:0] default_entry(input int idx);
        logic [11:0] p;
        if (idx >= DEFAULT_ENTRIES) return '0;
        p = DEFAULT_PALETTE[idx];
        return {COMP_W'(p[11:8]), COMP_W'(p[7:4]), COMP_W'(p[3:0])};
    endfunction

    // Bank-select codes that name a real bank; covers non-power-of-two bank counts.
    function automatic logic [2**BANK_W-1:0] bank_ok_mask();
        logic [2**BANK_W-1:0] m;
        for (int b = 0; b < 2**BANK_W; b++) m[b] = (b < NUM_BANKS);
        return m;
    endfunction

    localparam logic [2**BANK_W-1:0] BANK_OK = bank_ok_mask();

    logic [ENTRY_W-1:0] pal_q [NUM_BANKS][DEPTH];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < DEPTH; i++)
                    pal_q[b][i] <= default_entry(i);
        end else if (wr_en && BANK_OK[wr_bank]) begin
            pal_q[wr_bank][wr_index] <= wr_data;
        end
    end

    // Fade control
    fade_state_t         state_q, state_d;
    logic [COMP_W-1:0]   bright_q, bright_d;

    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        if (fade_restore) begin
            state_d  = IDLE;
            bright_d = BRIGHT_MAX;
        end else begin
            case (state_q)
                IDLE:   if (fade_start) state_d = FADING;
                FADING: if (fade_tick) begin
                    if (bright_q != '0) bright_d = bright_q - COMP_W'(1);
                    if (bright_q <= COMP_W'(1)) state_d = DARK;
                end
                DARK:   ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            bright_q <= BRIGHT_MAX;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
        end
    end

    // Stage 1: read the bank entry (pre-write value) and flag transparency
    logic               rd_ok;
    logic [ENTRY_W-1:0] rd_entry;
    logic               rd_transp;
    logic               vld_p1_q, transp_p1_q;
    logic [ENTRY_W-1:0] rgb_p1_q;

    assign rd_ok     = BANK_OK[in_bank];
    assign rd_entry  = rd_ok ? pal_q[in_bank][in_index] : '0;
    assign rd_transp = !rd_ok || (in_index == IDX_W'(TRANSP_IDX));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1_q    <= 1'b0;
            rgb_p1_q    <= '0;
            transp_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= in_valid;
            if (in_valid) begin
                rgb_p1_q    <= rd_entry;
                transp_p1_q <= rd_transp;
            end
        end
    end

    // Stage 2: scale by the brightness held during this stage
    logic [COMP_W-1:0]  r_scaled, g_scaled, b_scaled;
    logic               vld_p2_q, transp_p2_q;
    logic [ENTRY_W-1:0] rgb_p2_q;

    palette_scale #(.COMP_W(COMP_W)) u_scale_r (
        .comp_i(rgb_p1_q[3*COMP_W-1:2*COMP_W]), .level_i(bright_q), .scaled_o(r_scaled));
    palette_scale #(.COMP_W(COMP_W)) u_scale_g (
        .comp_i(rgb_p1_q[2*COMP_W-1:COMP_W]),   .level_i(bright_q), .scaled_o(g_scaled));
    palette_scale #(.COMP_W(COMP_W)) u_scale_b (
        .comp_i(rgb_p1_q[COMP_W-1:0]),          .level_i(bright_q), .scaled_o(b_scaled));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p2_q    <= 1'b0;
            rgb_p2_q    <= '0;
            transp_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                rgb_p2_q    <= {r_scaled, g_scaled, b_scaled};
                transp_p2_q <= transp_p1_q;
            end
        end
    end

    assign out_valid       = vld_p2_q;
    assign red             = rgb_p2_q[3*COMP_W-1:2*COMP_W];
    assign green           = rgb_p2_q[2*COMP_W-1:COMP_W];
    assign blue            = rgb_p2_q[COMP_W-1:0];
    assign out_transparent = transp_p2_q;
    assign fade_busy       = (state_q == FADING);
    assign brightness      = bright_q;

endmodule

// File: tb/tb_sprite_palette_unit.sv
// Directed plus randomized bench for sprite_palette_unit against a queue-based reference model.
module tb_sprite_palette_unit;

    localparam int IDX_W      = 4;
    localparam int COMP_W     = 4;
    localparam int NUM_BANKS  = 2;
    localparam int TRANSP_IDX = 0;
    localparam int BANK_W     = 1;
    localparam int DEPTH      = 16;
    localparam int MAXB       = 15;
    localparam int CMASK      = 15;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              in_valid;
    logic [BANK_W-1:0] in_bank;
    logic [IDX_W-1:0]  in_index;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_index;
    logic [11:0]       wr_data;
    logic              fade_start, fade_restore, fade_tick;
    logic              out_valid, out_transparent, fade_busy;
    logic [3:0]        red, green, blue, brightness;

    always #5 Clk = ~Clk;

    sprite_palette_unit #(
        .IDX_W(IDX_W), .COMP_W(COMP_W), .NUM_BANKS(NUM_BANKS), .TRANSP_IDX(TRANSP_IDX)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .in_valid(in_valid), .in_bank(in_bank), .in_index(in_index),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_data(wr_data),
        .fade_start(fade_start), .fade_restore(fade_restore), .fade_tick(fade_tick),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .out_transparent(out_transparent), .fade_busy(fade_busy), .brightness(brightness)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int default_pal [16] = '{
        'hF92, 'hFFF, 'h621, 'hFF0, 'hF31, 'hE97, 'h555, 'hFB1,
        'h221, 'hE64, 'hF71, 'hAAA, 'hFED, 'hFD0, 'hFBB, 'hA32
    };

    // Reference model: palette contents, fade mode (0 idle, 1 fading, 2 dark), pending results
    int mem [NUM_BANKS][DEPTH];
    int bright;
    int mode;
    typedef struct {
        int due;
        int r;
        int g;
        int b;
        int t;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int scale(input int c, input int b);
        return (c * (b + 1)) / (1 << COMP_W);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NUM_BANKS; b++)
            for (int i = 0; i < DEPTH; i++)
                mem[b][i] = default_pal[i];
        bright = MAXB;
        mode   = 0;
        q.delete();
    endtask

    task automatic model_edge();
        int   e;
        int   t;
        bit   ok;
        exp_t x;
        ok = (int'(in_bank) < NUM_BANKS);
        e  = ok ? mem[in_bank][in_index] : 0;
        t  = (!ok || int'(in_index) == TRANSP_IDX) ? 1 : 0;
        if (fade_restore) begin
            mode   = 0;
            bright = MAXB;
        end else if (mode == 0 && fade_start) begin
            mode = 1;
        end else if (mode == 1 && fade_tick) begin
            bright = bright - 1;
            if (bright == 0) mode = 2;
        end
        if (in_valid) begin
            x.due = cyc + 2;
            x.r   = scale((e >> (2*COMP_W)) & CMASK, bright);
            x.g   = scale((e >> COMP_W) & CMASK, bright);
            x.b   = scale(e & CMASK, bright);
            x.t   = t;
            q.push_back(x);
        end
        if (wr_en && int'(wr_bank) < NUM_BANKS)
            mem[wr_bank][wr_index] = int'(wr_data);
    endtask

    task automatic check_outputs();
        exp_t h;
        bit   ev;
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("out_valid", 32'(out_valid), ev ? 1 : 0);
        if (ev) begin
            h = q.pop_front();
            chk("red",   32'(red),   h.r);
            chk("green", 32'(green), h.g);
            chk("blue",  32'(blue),  h.b);
            chk("out_transparent", 32'(out_transparent), h.t);
        end
        chk("brightness", 32'(brightness), bright);
        chk("fade_busy",  32'(fade_busy),  (mode == 1) ? 1 : 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid",   32'(out_valid), 0);
        chk("rst_red",         32'(red), 0);
        chk("rst_green",       32'(green), 0);
        chk("rst_blue",        32'(blue), 0);
        chk("rst_transparent", 32'(out_transparent), 0);
        chk("rst_fade_busy",   32'(fade_busy), 0);
        chk("rst_brightness",  32'(brightness), MAXB);
    endtask

    task automatic step();
        @(posedge Clk);
        if (Reset_n) model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_bank      = '0;
        in_index     = '0;
        wr_en        = 1'b0;
        wr_bank      = '0;
        wr_index     = '0;
        wr_data      = '0;
        fade_start   = 1'b0;
        fade_restore = 1'b0;
        fade_tick    = 1'b0;
    endtask

    task automatic lookup(input int b, input int i);
        in_valid = 1'b1;
        in_bank  = BANK_W'(b);
        in_index = IDX_W'(i);
    endtask

    initial begin
        Reset_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs();
        Reset_n = 1'b1;
        step();

        // Plain lookups: opaque white, then transparent index 0
        lookup(0, 1); step(); idle(); step(); step();
        lookup(1, 0); step(); idle(); step(); step();

        // Write and lookup of the same entry in one cycle returns the old value
        lookup(0, 3);
        wr_en = 1'b1; wr_bank = 1'b0; wr_index = 4'd3; wr_data = 12'h0A5;
        step(); idle();
        lookup(0, 3); step(); idle(); step(); step();

        // Fade to half brightness, then look up a scaled entry
        fade_start = 1'b1; step(); idle();
        repeat (8) begin fade_tick = 1'b1; step(); end
        idle();
        chk("bright_after_8_ticks", 32'(brightness), 7);
        chk("busy_after_8_ticks",   32'(fade_busy), 1);
        lookup(0, 0); step(); idle(); step(); step();

        // Run to dark, ticks past zero, then simultaneous start+restore
        repeat (7) begin fade_tick = 1'b1; step(); end
        idle();
        chk("bright_dark",    32'(brightness), 0);
        chk("busy_dark",      32'(fade_busy), 0);
        repeat (3) begin fade_tick = 1'b1; step(); end
        chk("bright_hold_0",  32'(brightness), 0);
        idle();
        fade_start = 1'b1; fade_restore = 1'b1; step(); idle();
        chk("bright_restored", 32'(brightness), MAXB);
        chk("busy_restored",   32'(fade_busy), 0);

        // Randomized traffic
        repeat (400) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_bank      = BANK_W'($urandom_range(0, NUM_BANKS - 1));
            in_index     = IDX_W'($urandom_range(0, DEPTH - 1));
            wr_en        = ($urandom_range(0, 3) == 0);
            wr_bank      = BANK_W'($urandom_range(0, NUM_BANKS - 1));
            wr_index     = IDX_W'($urandom_range(0, DEPTH - 1));
            wr_data      = 12'($urandom_range(0, 4095));
            fade_start   = ($urandom_range(0, 31) == 0);
            fade_restore = ($urandom_range(0, 63) == 0);
            fade_tick    = ($urandom_range(0, 2) == 0);
            step();
        end
        idle(); step(); step(); step();

        // Mid-fade, mid-pipeline reset
        fade_start = 1'b1; step(); idle();
        repeat (3) begin fade_tick = 1'b1; step(); end
        idle();
        for (int i = 0; i < 16; i++) begin
            lookup(0, i);
            if (i == 8) begin
                #2;
                Reset_n = 1'b0;
                #1;
                check_reset_outputs();
                model_reset();
                step(); step();
                Reset_n = 1'b1;
                idle();
                repeat (4) step();
                break;
            end
            step();
        end
        idle();

        // Every entry of every bank is back to the default palette
        for (int b = 0; b < NUM_BANKS; b++)
            for (int i = 0; i < DEPTH; i++) begin
                lookup(b, i);
                step();
            end
        idle(); step(); step(); step();
        chk("queue_drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
